ram_port_arbiter: RTL and testbench

Shares one data-RAM port between two masters. Master 0 is the pipeline's MEM-stage data port. Master 1 is a secondary master such as DMA or debug loader. The block accepts a held request from each master, registers the winning request, drives the RAM port until it acknowledges, and returns read data plus a one-cycle ack to the owner. It provides fixed priority to master 0 with a starvation guard for master 1, and a per-access timeout.

---
 rtl/ram_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter : two-master arbiter for a single data-RAM port, fixed
//                    master-0 priority, master-1 starvation guard, timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [1:0]    m0_width,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [1:0]    m1_width,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_width,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          busy,
  output logic          owner
);

  localparam int                  c_SW          = $clog2(STARVE_LIM + 1);
  localparam int                  c_TW          = $clog2(TIMEOUT + 1);
  localparam logic [c_SW-1:0]     c_STARVE_MAX  = c_SW'(STARVE_LIM);
  localparam logic [c_TW-1:0]     c_TMO_LAST    = c_TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_SW-1:0] r_starve_cnt;
  logic [c_TW-1:0] r_tmo_cnt;
  logic            w_grant0;
  logic            w_grant1;
  logic            w_done;
  logic            w_tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        // master 1 only beats master 0 once it has been passed over STARVE_LIM times
        if (m1_req && (!m0_req || r_starve_cnt == c_STARVE_MAX)) begin
          w_grant1    = 1'b1;
          w_state_nxt = BUSY1;
        end else if (m0_req) begin
          w_grant0    = 1'b1;
          w_state_nxt = BUSY0;
        end
      end
      BUSY0, BUSY1: begin
        if (mem_ack) begin
          w_done = 1'b1;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_tmo = 1'b1;
        end
        if (w_done || w_tmo) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_width    <= 2'd0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      owner        <= 1'b0;
      m0_rdata     <= '0;
      m0_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m1_rdata     <= '0;
      m1_ack       <= 1'b0;
      m1_err       <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;

      if (w_grant0 || w_grant1) begin
        mem_req   <= 1'b1;
        mem_we    <= w_grant1 ? m1_we    : m0_we;
        mem_width <= w_grant1 ? m1_width : m0_width;
        mem_addr  <= w_grant1 ? m1_addr  : m0_addr;
        mem_wdata <= w_grant1 ? m1_wdata : m0_wdata;
        r_tmo_cnt <= '0;
        owner     <= w_grant1;
      end

      if (w_grant1) begin
        r_starve_cnt <= '0;
      end else if (w_grant0) begin
        if (!m1_req) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_STARVE_MAX) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end

      if (busy && !w_done && !w_tmo) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (w_done || w_tmo) begin
        mem_req <= 1'b0;
        if (r_state == BUSY1) begin
          m1_ack <= 1'b1;
          m1_err <= w_tmo;
          if (w_tmo) begin
            m1_rdata <= '0;
          end else if (!mem_we) begin
            m1_rdata <= mem_rdata;
          end
        end else begin
          m0_ack <= 1'b1;
          m0_err <= w_tmo;
          if (w_tmo) begin
            m0_rdata <= '0;
          end else if (!mem_we) begin
            m0_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// tb_ram_port_arbiter : directed self-checking bench for ram_port_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [1:0]  m0_width = 2'd0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [31:0] m0_rdata;
  logic        m0_ack, m0_err;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [1:0]  m1_width = 2'd0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [31:0] m1_rdata;
  logic        m1_ack, m1_err;
  logic        mem_req, mem_we;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack;
  logic        busy, owner;
  logic        ack_man = 1'b0;
  logic        zw = 1'b0;

  int checks   = 0;
  int failures = 0;

  assign mem_ack = ack_man | (zw & mem_req);

  always #5 clk = ~clk;

  ram_port_arbiter #(.AW(32), .DW(32), .STARVE_LIM(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_width(m0_width), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_width(m1_width), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .owner(owner)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, busy, owner, m0_ack, m1_ack, m0_err, m1_err, mem_we} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0", {mem_req, busy, owner, m0_ack, m1_ack, m0_err, m1_err, mem_we});
    end
    checks++;
    if ({m0_rdata, m1_rdata, mem_addr, mem_wdata} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {m0_rdata, m1_rdata, mem_addr, mem_wdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({mem_req, busy, owner, mem_we, mem_addr} !== {4'b1100, 32'h100}) begin
      failures++;
      $display("FAIL read_issue got=%b_%h exp=1100_00000100", {mem_req, busy, owner, mem_we}, mem_addr);
    end
    ack_man = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if ({m0_ack, m0_err, m1_ack, mem_req, m0_rdata} !== {4'b1000, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL read_ack got=%b_%h exp=1000_cafef00d", {m0_ack, m0_err, m1_ack, mem_req}, m0_rdata);
    end
    ack_man = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({m0_ack, m1_ack, busy} !== 3'b000) begin
      failures++;
      $display("FAIL read_after got=%b exp=000", {m0_ack, m1_ack, busy});
    end
  endtask

  task automatic test_contention();
    logic exp_own [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    mem_rdata = 32'h12345678; zw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, owner, mem_addr} !== {1'b1, exp_own[i], (exp_own[i] ? 32'h20 : 32'h10)}) begin
        failures++;
        $display("FAIL contend_owner[%0d] got=%b%b_%h exp_owner=%b", i, busy, owner, mem_addr, exp_own[i]);
      end
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack} !== {~exp_own[i], exp_own[i]}) begin
        failures++;
        $display("FAIL contend_ack[%0d] got=%b exp=%b", i, {m0_ack, m1_ack}, {~exp_own[i], exp_own[i]});
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; zw = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    m1_req = 1'b1; m1_we = 1'b1; m1_width = 2'd0; m1_addr = 32'h3; m1_wdata = 32'hAB;
    mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    checks++;
    if ({owner, mem_req, mem_we, mem_width, mem_addr, mem_wdata} !== {5'b11100, 32'h3, 32'hAB}) begin
      failures++;
      $display("FAIL write_issue got=%b_%h_%h", {owner, mem_req, mem_we, mem_width}, mem_addr, mem_wdata);
    end
    m1_wdata = 32'hFF; m1_addr = 32'h7;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_width, mem_addr, mem_wdata} !== {4'b1100, 32'h3, 32'hAB}) begin
      failures++;
      $display("FAIL write_stable got=%b_%h_%h", {mem_req, mem_we, mem_width}, mem_addr, mem_wdata);
    end
    ack_man = 1'b1;
    @(negedge clk);
    checks++;
    if ({m1_ack, m1_err, m0_ack, m1_rdata} !== {3'b100, 32'h12345678}) begin
      failures++;
      $display("FAIL write_ack got=%b_%h exp=100_12345678", {m1_ack, m1_err, m0_ack}, m1_rdata);
    end
    ack_man = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int  n   = 0;
    bit  got = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200; mem_rdata = 32'hDEADBEEF;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m0_ack) begin
        got = 1'b1;
        break;
      end
      if (mem_req) n++;
    end
    m0_req = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL tmo_ack_wait got=no_ack exp=ack_within_40");
    end
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL tmo_req_cycles got=%0d exp=16", n);
    end
    checks++;
    if ({m0_ack, m0_err, m1_ack, m0_rdata} !== {3'b110, 32'h0}) begin
      failures++;
      $display("FAIL tmo_result got=%b_%h exp=110_00000000", {m0_ack, m0_err, m1_ack}, m0_rdata);
    end
    repeat (2) @(negedge clk);
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    checks++;
    if ({m0_ack, m1_ack, busy} !== 3'b000) begin
      failures++;
      $display("FAIL tmo_late_ack got=%b exp=000", {m0_ack, m1_ack, busy});
    end
  endtask

  task automatic test_reset_mid();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
    @(negedge clk);
    checks++;
    if ({busy, owner, mem_req} !== 3'b111) begin
      failures++;
      $display("FAIL rmid_busy got=%b exp=111", {busy, owner, mem_req});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, busy, owner, m0_ack, m1_ack, m1_err, m1_rdata, mem_addr} !== {6'b0, 64'h0}) begin
      failures++;
      $display("FAIL rmid_zero got=%b_%h_%h exp=0", {mem_req, busy, owner, m0_ack, m1_ack, m1_err}, m1_rdata, mem_addr);
    end
    @(negedge clk);
    m1_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m1_ack, m0_ack, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rmid_noack got=%b exp=000", {m1_ack, m0_ack, busy});
    end
    m0_req = 1'b1; m0_addr = 32'h80; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if ({mem_req, busy, owner, mem_addr} !== {3'b110, 32'h80}) begin
      failures++;
      $display("FAIL rmid_regrant got=%b_%h exp=110_00000080", {mem_req, busy, owner}, mem_addr);
    end
    ack_man = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0_ack, m0_err, m0_rdata} !== {2'b10, 32'h0BADF00D}) begin
      failures++;
      $display("FAIL rmid_ack got=%b_%h exp=10_0badf00d", {m0_ack, m0_err}, m0_rdata);
    end
    ack_man = 1'b0; m0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stray_ack();
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    checks++;
    if ({m0_ack, m1_ack, busy, mem_req} !== 4'b0000) begin
      failures++;
      $display("FAIL stray_ack got=%b exp=0000", {m0_ack, m1_ack, busy, mem_req});
    end
    @(negedge clk);
    checks++;
    if ({m0_ack, m1_ack, busy, mem_req} !== 4'b0000) begin
      failures++;
      $display("FAIL stray_after got=%b exp=0000", {m0_ack, m1_ack, busy, mem_req});
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_timeout();
    test_reset_mid();
    test_stray_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
